// File: rtl/disp_pkg.sv
// disp_pkg: segment codes, decoder nibble selects and digit-slot encoding shared by the display path
package disp_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] ERR = 4'hE;
  typedef enum logic [1:0] {DIG_CNT_ONES, DIG_CNT_TENS, DIG_TAL_ONES, DIG_TAL_TENS} dig_e;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-high {g,f,e,d,c,b,a}; 0-9, E, anything else blank
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      ERR:  seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/count_display_scan.sv
// count_display_scan: samples an upstream counter, tallies MAX->0 wraps in BCD and scans both onto a 4-digit display
module count_display_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int MAX_COUNT      = 10,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       wrap_pulse,
  output logic [7:0] tally_bcd,
  output logic       err
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [3:0] MAX = 4'(MAX_COUNT);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
  logic [3:0] q_r_q, q_r_d, q_prev_q, q_prev_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d;
  logic [3:0] cnt_tens, cnt_ones, nib, an_q, an_d, an_hot;
  logic [PW-1:0] ps_q, ps_d;
  dig_e idx_q, idx_d;
  logic wrap_q, wrap_d, err_q, err_d, tick;
  logic [6:0] seg_hi, seg_q, seg_d;
  seg7_decode u_dec (.nib(nib), .seg(seg_hi));
  always_comb begin
    q_r_d = q_in;
    q_prev_d = q_r_q;
    wrap_d = q_prev_q == MAX && q_r_q == 4'd0;
    err_d = q_r_q > MAX;
    ones_d = wrap_q ? (ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1) : ones_q;
    tens_d = wrap_q && ones_q == 4'd9 ? (tens_q == 4'd9 ? 4'd0 : tens_q + 4'd1) : tens_q;
    tick = ps_q == PS_LAST;
    ps_d = tick ? '0 : ps_q + 1'b1;
    idx_d = tick ? dig_e'(idx_q + 2'd1) : idx_q;
    cnt_tens = q_r_q >= 4'd10 ? 4'd1 : 4'd0;
    cnt_ones = q_r_q - (q_r_q >= 4'd10 ? 4'd10 : 4'd0);
    // display sources are read live so a value change shows on the lit digit next cycle
    nib = idx_q == DIG_CNT_ONES ? (err_q ? BLANK : cnt_ones) :
          idx_q == DIG_CNT_TENS ? (err_q ? ERR : (cnt_tens == 4'd0 ? BLANK : cnt_tens)) :
          idx_q == DIG_TAL_ONES ? ones_q :
          (tens_q == 4'd0 ? BLANK : tens_q);
    an_hot = 4'b0001 << idx_q;
    seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_d = SEG_ACTIVE_LOW ? ~an_hot : an_hot;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r_q <= '0;
      q_prev_q <= '0;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
      ones_q <= '0;
      tens_q <= '0;
      ps_q <= '0;
      idx_q <= DIG_CNT_ONES;
      seg_q <= SEG_OFF;
      an_q <= AN_OFF;
    end else begin
      q_r_q <= q_r_d;
      q_prev_q <= q_prev_d;
      wrap_q <= wrap_d;
      err_q <= err_d;
      ones_q <= ones_d;
      tens_q <= tens_d;
      ps_q <= ps_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q <= an_d;
    end
  end
  assign seg = seg_q;
  assign an = an_q;
  assign wrap_pulse = wrap_q;
  assign tally_bcd = {tens_q, ones_q};
  assign err = err_q;
endmodule

// File: tb/tb_count_display_scan.sv
// tb_count_display_scan: random and directed stimulus checked every cycle against a history-based model
module tb_count_display_scan;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] q_in = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic wrap_pulse, err;
  logic [7:0] tally_bcd;
  int checks = 0, passed = 0, wraps_seen = 0;
  count_display_scan #(.REFRESH_DIV(4), .MAX_COUNT(10), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .seg(seg), .an(an),
    .wrap_pulse(wrap_pulse), .tally_bcd(tally_bcd), .err(err)
  );
  always #5 clk = ~clk;
  logic cap_rst = 1'b1;
  logic [3:0] cap_q = 4'd0;
  always @(posedge clk) begin
    cap_rst <= rst;
    cap_q <= q_in;
  end
  function automatic logic [6:0] code(int n);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return n < 10 ? tbl[n] : (n == 14 ? 7'h79 : 7'h00);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // model: last sampled values, wrap count since reset, edges since reset
  int hq[$];
  int j = 0, tcount = 0, qr, qp, d, t, n;
  bit armed = 1'b0, e_wrap = 1'b0, e_err = 1'b0;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_an = 4'hF;
  logic [7:0] e_tally = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (cap_rst) begin
        hq = '{0, 0};
        j = 0; tcount = 0; e_wrap = 0; e_err = 0;
        e_seg = 7'h7F; e_an = 4'hF; armed = 1'b1;
      end else if (armed) begin
        qr = hq[hq.size() - 1];
        qp = hq[hq.size() - 2];
        t = tcount % 100;
        d = (j / 4) % 4;
        case (d)
          0: n = e_err ? 15 : qr % 10;
          1: n = e_err ? 14 : (qr >= 10 ? 1 : 15);
          2: n = t % 10;
          default: n = (t / 10 == 0) ? 15 : t / 10;
        endcase
        e_seg = ~code(n);
        e_an = ~(4'(1) << d);
        tcount += int'(e_wrap);
        e_wrap = qp == 10 && qr == 0;
        e_err = qr > 10;
        hq.push_back(int'(cap_q));
        if (hq.size() > 4) void'(hq.pop_front());
        j++;
      end
      if (armed) begin
        e_tally = {4'((tcount % 100) / 10), 4'(tcount % 10)};
        chk("seg", 32'(seg), 32'(e_seg));
        chk("an", 32'(an), 32'(e_an));
        chk("wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
        chk("tally_bcd", 32'(tally_bcd), 32'(e_tally));
        chk("err", 32'(err), 32'(e_err));
      end
    end
  end
  task automatic drive(input logic r, input logic [3:0] q);
    rst = r;
    q_in = q;
    @(negedge clk);
    wraps_seen += int'(wrap_pulse);
  endtask
  task automatic sweeps(input int cnt);
    for (int s = 0; s < cnt; s++)
      for (int v = 0; v <= 10; v++) drive(1'b0, 4'(v));
    for (int z = 0; z < 3; z++) drive(1'b0, 4'd0);
  endtask
  initial begin
    int up, r;
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    an_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_exp = '{7'h40, 7'h7F, 7'h40, 7'h7F};
    drive(1'b1, 4'd0);
    drive(1'b1, 4'd0);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_tally", 32'(tally_bcd), 32'h00);
    chk("rst_wrap", 32'(wrap_pulse), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'd0);
      if (k % 4 == 0) begin
        chk("scan_an", 32'(an), 32'(an_exp[k / 4]));
        chk("scan_seg", 32'(seg), 32'(seg_exp[k / 4]));
      end
    end
    for (int v = 1; v <= 10; v++) drive(1'b0, 4'(v));
    drive(1'b0, 4'd0);
    chk("wrap_early", 32'(wrap_pulse), 32'h0);
    drive(1'b0, 4'd0);
    chk("wrap_first", 32'(wrap_pulse), 32'h1);
    drive(1'b0, 4'd0);
    chk("wrap_one_cycle", 32'(wrap_pulse), 32'h0);
    chk("tally_first", 32'(tally_bcd), 32'h01);
    drive(1'b0, 4'd5);
    drive(1'b0, 4'd5);
    for (int z = 0; z < 3; z++) begin
      drive(1'b0, 4'd0);
      chk("load0_nowrap", 32'(wrap_pulse), 32'h0);
    end
    chk("load0_tally", 32'(tally_bcd), 32'h01);
    drive(1'b0, 4'd13);
    drive(1'b0, 4'd13);
    chk("err_set", 32'(err), 32'h1);
    for (int k = 0; k < 16; k++) drive(1'b0, 4'd13);
    drive(1'b0, 4'd3);
    drive(1'b0, 4'd3);
    chk("err_clear", 32'(err), 32'h0);
    chk("err_tally", 32'(tally_bcd), 32'h01);
    drive(1'b1, 4'd0);
    sweeps(37);
    chk("tally_37", 32'(tally_bcd), 32'h37);
    for (int k = 0; k < 5; k++) drive(1'b0, 4'd0);
    drive(1'b1, 4'd0);
    chk("midrst_tally", 32'(tally_bcd), 32'h00);
    chk("midrst_an", 32'(an), 32'hF);
    drive(1'b0, 4'd0);
    chk("restart_an", 32'(an), 32'hE);
    drive(1'b1, 4'd0);
    wraps_seen = 0;
    sweeps(10);
    chk("tally_10", 32'(tally_bcd), 32'h10);
    sweeps(90);
    chk("tally_wrap_00", 32'(tally_bcd), 32'h00);
    chk("wraps_100", 32'(wraps_seen), 32'd100);
    up = 0;
    repeat (3000) begin
      if ($urandom_range(0, 249) == 0) begin
        drive(1'b1, 4'd0);
        up = 0;
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 6) up = int'($urandom_range(0, 15));
        else if (r < 12) up = 10;
        else up = (up >= 10) ? 0 : up + 1;
        drive(1'b0, 4'(up));
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/count_display_scan.md
Name: count_display_scan

Overview:
- Downstream consumer of the 4-bit mod-(MAX_COUNT+1) counter output, which counts 0..10 with a parallel load.
- Samples the count every clock.
- Detects natural wrap events (MAX_COUNT -> 0) and tallies them in a 2-digit BCD counter.
- Time-multiplexes count and tally onto a 4-digit common-anode 7-segment display.

Parameters:
- REFRESH_DIV, 50000: clocks per digit slot; legal range >= 2.
- MAX_COUNT, 10: upstream terminal value; legal range 1..15. The wrap is defined as sampled MAX_COUNT followed by sampled 0.
- SEG_ACTIVE_LOW, 1: 1 = seg and an outputs driven low-true; 0 = high-true.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- q_in  in  4  upstream counter value
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}
- an  out  4  digit enables; an[0] is the rightmost digit
- wrap_pulse  out  1  one-cycle strobe per detected wrap
- tally_bcd  out  8  wrap tally {tens,ones} in BCD, 00..99
- err  out  1  high while the sampled count exceeds MAX_COUNT

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - q_r=0, q_prev=0, tally=00, prescaler=0, digit index=0, wrap_pulse=0, err=0.
  - seg and an at inactive level: all 1 if SEG_ACTIVE_LOW, else all 0.
  - Reset asserted mid-scan or mid-tally aborts immediately; no partial state survives.
- Sampling: q_r<=q_in and q_prev<=q_r every cycle. q_in is synchronous to clk; no synchroniser.
- Wrap detect:
  - wrap_pulse<=1 for exactly one cycle when q_prev==MAX_COUNT && q_r==0. Pulse appears 2 cycles after q_in shows 0.
  - Transitions to 0 by upstream load or reset from other values do not count.
  - MAX_COUNT reached by load and then wrapping does count, since only the value pair matters.
- Tally:
  - BCD ones/tens counter, increments on wrap_pulse.
  - Ones 9->0 carries into tens; 99->00 wraps silently, no saturation.
  - Updated the cycle after wrap_pulse. tally_bcd is registered.
- Count digits:
  - Source is q_r.
  - tens = (q_r>=10) ? 1 : 0; ones = q_r - 10*tens. Widths are 4 bits; no divider needed since q_r<=15.
- Error:
  - err<=1 whenever q_r>MAX_COUNT.
  - While err=1, digits 1:0 show "E" on digit 1 and blank on digit 0. The tally is unaffected.
- Leading-zero blanking: digit 1 blanked when the count tens==0. Digit 3 blanked when tally tens==0. Digits 0 and 2 are never blanked.
- Prescaler:
  - Counts 0..REFRESH_DIV-1. tick when at REFRESH_DIV-1, then returns to 0.
  - On tick, digit index increments 0->1->2->3->0.
- Scan state machine (digit index):
  - 0 = count ones, 1 = count tens, 2 = tally ones, 3 = tally tens.
  - Exactly one an bit active per state.
- Output timing:
  - seg/an registered; they follow the digit index with 1-cycle latency.
  - Display values are taken live at that register, so a change shows within one cycle on the currently lit digit.
- Segment codes (active-high form):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, E=79, blank=00.
  - Inverted at output when SEG_ACTIVE_LOW.
- Simultaneous events: a wrap and a tick in the same cycle are independent; both take effect.

Decomposition:
- Shared package `disp_pkg`:
  - SEG_* localparams for codes 0-9, E and blank.
  - Digit-index encoding constants DIG_CNT_ONES..DIG_TAL_TENS.
  - Nibble code BLANK=4'hF and ERR=4'hE for the decoder select.
- Sub-module `seg7_decode`: purely combinational, nibble -> 7-bit active-high pattern, 0-9, E, F=blank. It is instantiated once after the digit mux.
- All other logic (sampling, wrap detect, tally, prescaler, scan) stays in the top.

Test Plan (REFRESH_DIV=4, MAX_COUNT=10, SEG_ACTIVE_LOW=1):
- Reset, then hold q_in=0 -> seg=7F/an=F during reset. After release: an cycles E,D,B,7 with 4 clocks per slot. Digit 0 seg=40 ("0"), digits 1 and 3 show seg=7F (blanked), digit 2 "0".
- Drive q_in 0,1..10,0 one value per clock -> single wrap_pulse 2 cycles after 0 is presented; tally_bcd=8'h01 next cycle. During digit 1 the slot shows "1" (seg=79) while q_r=10.
- Drive upstream-style sequence 5 -> load 0 (q_in=0) -> wrap_pulse stays 0, tally unchanged.
- Apply 100 full 0..10 sweeps -> tally_bcd passes 09->10 and 99->00. Final tally_bcd=8'h00, 100 wrap_pulses counted.
- q_in=13 -> err=1 two cycles later; digit 1 shows "E" (seg=06), digit 0 blank (seg=7F). Tally digits unchanged. Return to q_in=3 -> err clears.
- Assert rst for 1 cycle mid-scan with tally=8'h37 -> tally=00, an=F, and index restarts at digit 0 on the first tick after release.
